memory_access_stage: RTL

//  MEM pipeline stage plus MEM/WB pipeline register. Takes the EX/MEM bundle, performs

---
 rtl/memory_access_stage_if.sv | 22 ++
 rtl/memory_access_stage.sv | 133 +++++++++++++
 2 files changed

// File: rtl/memory_access_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage (master) and data memory (slave).
// Address is a word address; the payload is a single 32-bit word.
interface memory_access_stage_if #(
  parameter int ADDR_W = 14
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/memory_access_stage.sv
// MEM pipeline stage with MEM/WB register: word loads/stores over a req/ack port,
// upstream stall while an access is outstanding, timeout abort and sticky error flag.
module memory_access_stage #(
  parameter int ADDR_W  = 14,
  parameter int RD_W    = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [31:0]           ALU_result,
  input  logic [31:0]           store_data,
  input  logic                  MemR,
  input  logic                  MemW,
  input  logic                  WBSel,
  input  logic                  WR,
  input  logic [RD_W-1:0]       Rd,
  output logic                  stall,
  memory_access_stage_if.master mem,
  output logic                  out_valid,
  output logic [31:0]           ALU_result_out,
  output logic [31:0]           MEM_Data,
  output logic                  WBSel_out,
  output logic                  WR_out,
  output logic [RD_W-1:0]       Rd_out,
  output logic                  mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt_p0;

  logic             r_vld_p1;
  logic [31:0]      r_alu_p1;
  logic [31:0]      r_mem_data_p1;
  logic             r_wbsel_p1;
  logic             r_wr_p1;
  logic [RD_W-1:0]  r_rd_p1;
  logic             r_err;

  logic w_is_mem, w_misalign, w_access;
  logic w_load, w_bubble, w_abort, w_take_data, w_wr_nxt;

  assign w_is_mem   = in_valid & (MemR | MemW);
  assign w_misalign = w_is_mem & (ALU_result[1:0] != 2'b00);
  assign w_access   = w_is_mem & (ALU_result[1:0] == 2'b00);

  // Address/data/direction come straight from the held EX/MEM inputs.
  assign mem.mem_req   = (r_state == S_WAIT);
  assign mem.mem_we    = MemW;
  assign mem.mem_addr  = ALU_result[ADDR_W+1:2];
  assign mem.mem_wdata = store_data;

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    w_load      = 1'b0;
    w_bubble    = 1'b0;
    w_abort     = 1'b0;
    w_take_data = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          stall       = 1'b1;
          w_bubble    = 1'b1;
          w_state_nxt = S_WAIT;
        end else begin
          w_load = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem.mem_ack) begin
          w_load      = 1'b1;
          w_take_data = ~MemW;
          w_state_nxt = S_IDLE;
        end else if (r_cnt_p0 == CNT_W'(TIMEOUT - 1)) begin
          w_load      = 1'b1;
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          stall    = 1'b1;
          w_bubble = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A squashed (misaligned or aborted) access still retires, but never writes a register.
  assign w_wr_nxt = WR & in_valid & ~w_misalign & ~w_abort;

  // ---- MEM -> MEM/WB boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt_p0      <= '0;
      r_vld_p1      <= 1'b0;
      r_alu_p1      <= '0;
      r_mem_data_p1 <= '0;
      r_wbsel_p1    <= 1'b0;
      r_wr_p1       <= 1'b0;
      r_rd_p1       <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt_p0 <= (r_state == S_WAIT && w_state_nxt == S_WAIT) ? r_cnt_p0 + 1'b1 : '0;
      if (w_load) begin
        r_vld_p1   <= in_valid;
        r_alu_p1   <= ALU_result;
        r_wbsel_p1 <= WBSel;
        r_wr_p1    <= w_wr_nxt;
        r_rd_p1    <= Rd;
        if (w_take_data) r_mem_data_p1 <= mem.mem_rdata;
      end else if (w_bubble) begin
        r_vld_p1 <= 1'b0;
        r_wr_p1  <= 1'b0;
      end
      if (w_abort || (w_load && w_misalign)) r_err <= 1'b1;
    end
  end

  assign out_valid      = r_vld_p1;
  assign ALU_result_out = r_alu_p1;
  assign MEM_Data       = r_mem_data_p1;
  assign WBSel_out      = r_wbsel_p1;
  assign WR_out         = r_wr_p1;
  assign Rd_out         = r_rd_p1;
  assign mem_err        = r_err;

endmodule
